// File: rtl/uvma_apb_mstr_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uvma_apb_mstr_arb_pkg
// Brief    : Shared types, width helper and reset values for the APB master arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package uvma_apb_mstr_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_e;

   // A single requester still needs a one-bit owner index.
   function automatic int owner_width(input int num_req);
      return (num_req > 1) ? $clog2(num_req) : 1;
   endfunction

   localparam apb_state_e c_rst_state = IDLE;
   localparam logic       c_rst_bit   = 1'b0;

endpackage
`default_nettype wire

// File: rtl/uvma_apb_rr_arb.sv
`default_nettype none
// ============================================================================
// Module   : uvma_apb_rr_arb
// Brief    : Combinational round-robin picker: first request at or after the pointer, with wrap.
// Revision : 1.0 - initial release
// ============================================================================
module uvma_apb_rr_arb
   import uvma_apb_mstr_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = owner_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IDX_W-1:0]   i_ptr,
   input  logic               i_en,
   output logic [NUM_REQ-1:0] o_gnt,
   output logic [IDX_W-1:0]   o_idx,
   output logic               o_any
);

   logic [IDX_W-1:0] w_cand;

   always_comb begin
      o_gnt  = '0;
      o_idx  = '0;
      o_any  = 1'b0;
      w_cand = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_cand = IDX_W'((int'(i_ptr) + k) % NUM_REQ);
         if (i_en && !o_any && i_req[w_cand]) begin
            o_any         = 1'b1;
            o_gnt[w_cand] = 1'b1;
            o_idx         = w_cand;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/uvma_apb_mstr_arb.sv
`default_nettype none
// ============================================================================
// Module   : uvma_apb_mstr_arb
// Brief    : Round-robin arbiter sharing one APB master port among NUM_REQ clients.
// Revision : 1.0 - initial release
// ============================================================================
module uvma_apb_mstr_arb
   import uvma_apb_mstr_arb_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 0
) (
   input  logic                          pclk,
   input  logic                          presetn,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ-1:0]            req_write,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
   output logic [NUM_REQ-1:0]            rsp_valid,
   output logic [DATA_WIDTH-1:0]         rsp_rdata,
   output logic                          rsp_slverr,
   output logic [ADDR_WIDTH-1:0]         paddr,
   output logic                          psel,
   output logic                          penable,
   output logic                          pwrite,
   output logic [DATA_WIDTH-1:0]         pwdata,
   input  logic                          pready,
   input  logic [DATA_WIDTH-1:0]         prdata,
   input  logic                          pslverr
);

   localparam int c_idx_w = owner_width(NUM_REQ);
   localparam int c_tmo_w = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   apb_state_e            r_state;
   apb_state_e            w_state_nxt;
   logic [c_idx_w-1:0]    r_ptr;
   logic [c_idx_w-1:0]    r_owner;
   logic [c_tmo_w-1:0]    r_tmo_cnt;
   logic [ADDR_WIDTH-1:0] r_paddr;
   logic                  r_pwrite;
   logic [DATA_WIDTH-1:0] r_pwdata;
   logic [NUM_REQ-1:0]    r_rsp_valid;
   logic [DATA_WIDTH-1:0] r_rsp_rdata;
   logic                  r_rsp_slverr;

   logic                  w_grant_en;
   logic                  w_any;
   logic [NUM_REQ-1:0]    w_gnt;
   logic [c_idx_w-1:0]    w_idx;
   logic                  w_timeout;
   logic                  w_done;

   // Grants happen from IDLE or on the completing ACCESS cycle (back-to-back).
   assign w_grant_en = presetn &&
                       ((r_state == IDLE) || ((r_state == ACCESS) && pready));

   assign w_timeout  = (TIMEOUT_CYCLES > 0) && (r_state == ACCESS) && !pready &&
                       (r_tmo_cnt == c_tmo_w'(TIMEOUT_CYCLES - 1));
   assign w_done     = (r_state == ACCESS) && (pready || w_timeout);

   uvma_apb_rr_arb #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (c_idx_w)
   ) u_rr_arb (
      .i_req   (req_valid),
      .i_ptr   (r_ptr),
      .i_en    (w_grant_en),
      .o_gnt   (w_gnt),
      .o_idx   (w_idx),
      .o_any   (w_any)
   );

   assign req_ready  = w_gnt;
   assign rsp_valid  = r_rsp_valid;
   assign rsp_rdata  = r_rsp_rdata;
   assign rsp_slverr = r_rsp_slverr;
   assign paddr      = r_paddr;
   assign pwrite     = r_pwrite;
   assign pwdata     = r_pwdata;

   always_comb begin
      w_state_nxt = r_state;
      psel        = 1'b0;
      penable     = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_any) w_state_nxt = SETUP;
         end
         SETUP: begin
            psel        = 1'b1;
            w_state_nxt = ACCESS;
         end
         ACCESS: begin
            psel    = 1'b1;
            penable = 1'b1;
            if (w_timeout)   w_state_nxt = IDLE;
            else if (pready) w_state_nxt = w_any ? SETUP : IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge pclk) begin
      if (!presetn) begin
         r_state      <= c_rst_state;
         r_ptr        <= '0;
         r_owner      <= '0;
         r_tmo_cnt    <= '0;
         r_paddr      <= '0;
         r_pwrite     <= c_rst_bit;
         r_pwdata     <= '0;
         r_rsp_valid  <= '0;
         r_rsp_rdata  <= '0;
         r_rsp_slverr <= c_rst_bit;
      end else begin
         r_state     <= w_state_nxt;
         r_rsp_valid <= '0;

         if (w_any) begin
            r_paddr  <= req_addr[int'(w_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            r_pwrite <= req_write[w_idx];
            r_pwdata <= req_wdata[int'(w_idx)*DATA_WIDTH +: DATA_WIDTH];
            r_owner  <= w_idx;
            r_ptr    <= (w_idx == c_idx_w'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
         end

         if (w_state_nxt == SETUP)
            r_tmo_cnt <= '0;
         else if ((r_state == ACCESS) && !pready)
            r_tmo_cnt <= r_tmo_cnt + 1'b1;

         // Write completions and timeouts return zero data.
         if (w_done) begin
            r_rsp_valid[r_owner] <= 1'b1;
            r_rsp_rdata          <= (r_pwrite || w_timeout) ? '0 : prdata;
            r_rsp_slverr         <= w_timeout ? 1'b1 : pslverr;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_uvma_apb_mstr_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_uvma_apb_mstr_arb
// Brief    : Directed bench with an APB slave model and a response scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uvma_apb_mstr_arb;

   localparam int N   = 4;
   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int TMO = 8;

   logic          pclk = 1'b0;
   logic          presetn;
   logic [N-1:0]  req_valid, req_ready, req_write, rsp_valid;
   logic [N*AW-1:0] req_addr;
   logic [N*DW-1:0] req_wdata;
   logic [DW-1:0] rsp_rdata, pwdata, prdata;
   logic [AW-1:0] paddr;
   logic          rsp_slverr, psel, penable, pwrite, pready, pslverr;

   uvma_apb_mstr_arb #(
      .NUM_REQ        (N),
      .ADDR_WIDTH     (AW),
      .DATA_WIDTH     (DW),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .pclk       (pclk),
      .presetn    (presetn),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_addr   (req_addr),
      .req_write  (req_write),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .rsp_slverr (rsp_slverr),
      .paddr      (paddr),
      .psel       (psel),
      .penable    (penable),
      .pwrite     (pwrite),
      .pwdata     (pwdata),
      .pready     (pready),
      .prdata     (prdata),
      .pslverr    (pslverr)
   );

   always #5 pclk = ~pclk;

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;

   always @(posedge pclk) cyc <= cyc + 1;

   typedef struct {
      int            client;
      logic [DW-1:0] rdata;
      logic          err;
      int            due;
   } exp_t;

   exp_t exp_q[$];

   int            slv_ws    = 0;
   logic [DW-1:0] slv_rdata = '0;
   logic          slv_err   = 1'b0;
   int            acc_cnt   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
   endtask

   // Slave: pready low for slv_ws ACCESS cycles, then high.
   initial begin
      pready  = 1'b0;
      prdata  = '0;
      pslverr = 1'b0;
      forever begin
         @(posedge pclk);
         #1;
         if (psel && penable) begin
            pready  = (acc_cnt == slv_ws);
            prdata  = pready ? slv_rdata : '0;
            pslverr = pready ? slv_err : 1'b0;
            acc_cnt++;
         end else begin
            pready  = 1'b0;
            prdata  = '0;
            pslverr = 1'b0;
            acc_cnt = 0;
         end
      end
   end

   // Response monitor
   initial begin
      exp_t e;
      forever begin
         @(negedge pclk);
         if (rsp_valid !== '0) begin
            if (exp_q.size() == 0) begin
               check("rsp_unexpected", 64'(rsp_valid), 64'(0));
            end else begin
               e = exp_q.pop_front();
               check("rsp_valid", 64'(rsp_valid), 64'(1) << e.client);
               check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
               check("rsp_slverr", 64'(rsp_slverr), 64'(e.err));
               check("rsp_cycle", 64'(cyc), 64'(e.due));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic issue(input int c, input logic [AW-1:0] a, input logic w,
                        input logic [DW-1:0] d, output int acc, output bit ok);
      @(posedge pclk);
      #1;
      req_addr[c*AW +: AW]  = a;
      req_write[c]          = w;
      req_wdata[c*DW +: DW] = d;
      req_valid[c]          = 1'b1;
      ok  = 1'b0;
      acc = 0;
      for (int k = 0; k < 50 && !ok; k++) begin
         @(negedge pclk);
         if (req_ready[c]) begin
            ok  = 1'b1;
            acc = cyc;
         end
      end
      check("req_accepted", 64'(ok), 64'(1));
      @(posedge pclk);
      #1;
      req_valid[c] = 1'b0;
   endtask

   task automatic single(input int c, input logic [AW-1:0] a, input logic w,
                         input logic [DW-1:0] d, input int ws, input logic [DW-1:0] rd,
                         input logic er, input logic [DW-1:0] exp_rd, input logic exp_er);
      int acc, acc_len, held;
      bit ok;
      slv_ws    = ws;
      slv_rdata = rd;
      slv_err   = er;
      acc_len   = (ws + 1 > TMO) ? TMO : ws + 1;
      held      = 0;
      issue(c, a, w, d, acc, ok);
      if (ok) begin
         exp_q.push_back('{c, exp_rd, exp_er, acc + 2 + acc_len});
         @(negedge pclk);
         check("setup_sel_en", 64'({psel, penable}), 64'(2'b10));
         check("setup_paddr", 64'(paddr), 64'(a));
         check("setup_pwrite", 64'(pwrite), 64'(w));
         for (int k = 0; k < acc_len; k++) begin
            @(negedge pclk);
            if (psel && penable && paddr == a && pwrite == w && (!w || pwdata == d)) held++;
         end
         check("access_held", 64'(held), 64'(acc_len));
         @(negedge pclk);
         check("bus_idle_after", 64'({psel, penable}), 64'(0));
      end
   endtask

   int order_exp[5] = '{0, 1, 2, 3, 0};
   int rem[N];
   int ngr, gaps, win, acc6;
   bit ok6;

   initial begin
      presetn   = 1'b0;
      req_valid = '1;
      req_write = '0;
      req_addr  = '0;
      req_wdata = '0;
      repeat (2) @(negedge pclk);
      check("rst_apb_ctl", 64'({psel, penable, pwrite}), 64'(0));
      check("rst_paddr", 64'(paddr), 64'(0));
      check("rst_pwdata", 64'(pwdata), 64'(0));
      check("rst_rsp", 64'({rsp_valid, rsp_slverr}), 64'(0));
      check("rst_rdata", 64'(rsp_rdata), 64'(0));
      check("rst_ready", 64'(req_ready), 64'(0));
      req_valid = '0;
      presetn   = 1'b1;

      // Single read, write with wait states, slave error read, timeout
      single(2, 32'h40, 1'b0, 32'h0, 0, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0);
      single(0, 32'h10, 1'b1, 32'h1234, 3, 32'h5555AAAA, 1'b0, 32'h0, 1'b0);
      single(1, 32'h24, 1'b0, 32'h0, 1, 32'hCAFE0001, 1'b1, 32'hCAFE0001, 1'b1);
      single(3, 32'h80, 1'b0, 32'h0, 1000, 32'h77777777, 1'b0, 32'h0, 1'b1);

      // Round-robin with all clients requesting, pointer from reset
      @(negedge pclk);
      presetn = 1'b0;
      repeat (2) @(negedge pclk);
      presetn = 1'b1;
      @(posedge pclk);
      #1;
      slv_ws    = 0;
      slv_rdata = 32'h0BADF00D;
      slv_err   = 1'b0;
      for (int i = 0; i < N; i++) begin
         req_addr[i*AW +: AW]  = 32'h100 + 32'(i * 16);
         req_write[i]          = i[0];
         req_wdata[i*DW +: DW] = 32'hA000 + 32'(i);
         rem[i]                = (i == 0) ? 2 : 1;
      end
      req_valid = '1;
      ngr  = 0;
      gaps = 0;
      for (int t = 0; t < 100 && ngr < 5; t++) begin
         @(negedge pclk);
         if (ngr > 0 && !psel) gaps++;
         if (req_ready != '0) begin
            check("rr_ready_onehot", 64'($onehot(req_ready)), 64'(1));
            win = 0;
            for (int i = 0; i < N; i++) if (req_ready[i]) win = i;
            check("rr_order", 64'(win), 64'(order_exp[ngr]));
            exp_q.push_back('{win, req_write[win] ? 32'h0 : 32'h0BADF00D, 1'b0, cyc + 3});
            ngr++;
            rem[win]--;
            @(posedge pclk);
            #1;
            if (rem[win] == 0) req_valid[win] = 1'b0;
         end
      end
      req_valid = '0;
      check("rr_grants", 64'(ngr), 64'(5));
      check("rr_no_idle_gap", 64'(gaps), 64'(0));
      for (int t = 0; t < 20 && exp_q.size() > 0; t++) @(negedge pclk);

      // Reset in the middle of an ACCESS
      slv_ws = 1000;
      issue(1, 32'h30, 1'b0, 32'h0, acc6, ok6);
      @(negedge pclk);
      @(negedge pclk);
      check("mid_access", 64'({psel, penable}), 64'(2'b11));
      presetn   = 1'b0;
      req_valid = 4'b1010;
      @(negedge pclk);
      check("rst_abort_bus", 64'({psel, penable}), 64'(0));
      check("rst_abort_rsp", 64'(rsp_valid), 64'(0));
      check("rst_ready_low", 64'(req_ready), 64'(0));
      @(negedge pclk);
      presetn = 1'b1;
      #1;
      check("rst_ptr_zero", 64'(req_ready), 64'(4'b0010));
      req_valid = '0;
      repeat (4) @(negedge pclk);

      check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/uvma_apb_mstr_arb.md
Name: uvma_apb_mstr_arb

Overview:
- Round-robin arbiter and APB transfer sequencer.
- Shares one APB master port between NUM_REQ simple request/response clients.
- Drives the APB SETUP/ACCESS protocol, waits on pready, returns prdata/pslverr to the granted client, and applies an optional pready timeout.
- Sits between on-chip requesters (or test drivers) and the master side of the bus that uvma_apb_if models.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- ADDR_WIDTH, 32, paddr width.
- DATA_WIDTH, 32, pwdata/prdata width.
- TIMEOUT_CYCLES, 0, maximum ACCESS cycles with pready low before forced error; 0 disables the timeout.

Ports:
- pclk  in  1  clock.
- presetn  in  1  synchronous active-low reset.
- req_valid  in  NUM_REQ  per-client request.
- req_ready  out  NUM_REQ  per-client accept (one-hot or zero).
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; client i at slice i.
- req_write  in  NUM_REQ  1 = write.
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data.
- rsp_valid  out  NUM_REQ  one-cycle completion pulse to the owning client.
- rsp_rdata  out  DATA_WIDTH  shared read data; valid only with rsp_valid.
- rsp_slverr  out  1  shared error flag; valid only with rsp_valid.
- paddr  out  ADDR_WIDTH  APB address.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- pwdata  out  DATA_WIDTH  APB write data.
- pready  in  1  APB ready.
- prdata  in  DATA_WIDTH  APB read data.
- pslverr  in  1  APB error.

Behaviour:
- Clock and reset: single clock pclk. Reset is synchronous and active-low on presetn.
- Reset values:
  - State IDLE, grant pointer 0, timeout counter 0.
  - psel, penable, pwrite = 0; paddr, pwdata = 0.
  - rsp_valid = 0, rsp_rdata = 0, rsp_slverr = 0.
  - req_ready = 0 while presetn is low.
- States:
  - IDLE: psel=0, penable=0.
  - SETUP: psel=1, penable=0. Always lasts exactly one cycle.
  - ACCESS: psel=1, penable=1.
- Client handshake:
  - A request is accepted on req_valid[i] & req_ready[i].
  - A client holds addr/write/wdata stable while valid && !ready.
  - req_valid must not depend on req_ready.
- Grant:
  - req_ready is combinational.
  - A grant is possible in IDLE, or in ACCESS when pready=1 (back-to-back transfers).
  - The winner is the first asserted req_valid at or after the pointer, searching upward with wrap.
  - On accept: the client's fields are latched into paddr/pwrite/pwdata, the owner index is stored, pointer = winner+1 mod NUM_REQ, next state SETUP.
  - No valid requests: no grant; next state IDLE (from ACCESS completion) or stay IDLE.
- ACCESS, pready=0: stay in ACCESS and hold all APB outputs.
- ACCESS, pready=1:
  - Next cycle: rsp_valid[owner]=1 for one cycle.
  - rsp_rdata = prdata for reads and 0 for writes.
  - rsp_slverr = pslverr.
  - penable falls. psel stays 1 only if a new grant happened in the same cycle.
- Minimum latency: accept at cycle 0, SETUP at 1, ACCESS at 2, pready sampled at 2, rsp_valid at 3.
- Back-to-back: completion and new SETUP follow without an IDLE cycle. In that case rsp_valid for the old owner and SETUP for the new owner coincide.
- Timeout (TIMEOUT_CYCLES>0):
  - The counter counts ACCESS cycles with pready=0 and clears on entering SETUP.
  - When the count reaches TIMEOUT_CYCLES, that cycle is treated as a completion with rsp_slverr=1 and rsp_rdata=0.
  - psel/penable drop; next state IDLE, with no back-to-back grant that cycle.
- Simultaneous requests: exactly one grant per cycle. The others stay pending with req_ready=0.
- Same client re-requests immediately: it is treated like any other client; round-robin prevents starvation.
- Reset mid-transfer: the transfer is abandoned, no rsp_valid is issued, and the bus returns to idle on the next cycle.
- rsp_valid is never asserted for more than one bit per cycle.

Decomposition:
- Package uvma_apb_mstr_arb_pkg holds:
  - the state enum (IDLE, SETUP, ACCESS);
  - the owner-index width function clog2(NUM_REQ);
  - the reset constants.
- Sub-module uvma_apb_rr_arb: purely combinational round-robin picker.
  - Inputs: req vector, pointer, enable.
  - Outputs: one-hot grant, index, any.
- The timeout counter and FSM live in the top module.

Test Plan:
- Single read, client 2, addr 0x40, pready high in first ACCESS, prdata 0xDEADBEEF -> req_ready[2] at cycle 0; SETUP at 1 with paddr 0x40, pwrite 0; rsp_valid[2] at cycle 3 with rsp_rdata 0xDEADBEEF, rsp_slverr 0.
- Write wait states, client 0, addr 0x10, wdata 0x1234, pready low 3 cycles -> penable held 4 cycles with pwdata stable at 0x1234; rsp_valid[0] with rsp_rdata 0.
- All 4 clients valid continuously, pointer 0 -> grant order 0,1,2,3,0; SETUP directly after each ACCESS with no IDLE cycle.
- pslverr=1 on a read from client 1 -> rsp_slverr=1 with rsp_valid[1].
- TIMEOUT_CYCLES=8, pready never asserted -> after 8 ACCESS cycles rsp_valid=1 with rsp_slverr=1; psel=0 on the next cycle.
- presetn low during ACCESS -> next cycle psel=0, penable=0, no rsp_valid; the next grant starts from pointer 0.
